move_checker_seq: RTL and testbench



---
 rtl/game_pkg.sv | 33 +++
 rtl/tile_pair_mergeable.sv | 19 +
 rtl/move_checker_seq.sv | 196 +++++++++++++++++++
 tb/tb_move_checker_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Package     : game_pkg
// Description : Shared 2048 game types: slide-direction codes, checker FSM
//               states and the direction-priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } mc_state_t;

    // Directions are serviced from the highest mask bit downwards.
    function automatic logic [3:0] msb_onehot(input logic [3:0] m);
        logic [3:0] r;
        r = 4'b0000;
        if (m[3])      r = DIR_LEFT;
        else if (m[2]) r = DIR_DOWN;
        else if (m[1]) r = DIR_UP;
        else if (m[0]) r = DIR_RIGHT;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_pair_mergeable.sv
`default_nettype none
// ============================================================================
// Module      : tile_pair_mergeable
// Description : A source tile can move onto its neighbour if it is occupied
//               and the neighbour is empty or holds the same value.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_pair_mergeable #(
    parameter int W = 12
) (
    input  logic [W-1:0] src,
    input  logic [W-1:0] dst,
    output logic         hit
);

    assign hit = (src != '0) && ((dst == '0) || (dst == src));

endmodule
`default_nettype wire

// File: rtl/move_checker_seq.sv
`default_nettype none
// ============================================================================
// Module      : move_checker_seq
// Description : Sequential 2048 move-possibility checker over a snapshot of
//               the board. Build option MOVE_CHECK_LINE_PARALLEL_EN scans all
//               lines of one position per cycle instead of one pair.
// Revision    : 1.0 - initial release
// ============================================================================
module move_checker_seq #(
    parameter int N = 4,
    parameter int W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [3:0]                    dir_mask,
    input  logic [N-1:0][N-1:0][W-1:0]    matrix,
    output logic                          busy,
    output logic                          done,
    output logic [3:0]                    can_move,
    output logic                          any_move,
    output logic                          game_over
);
    import game_pkg::*;

    typedef logic [W-1:0] tile_t;

    localparam int               LW         = $clog2(N);
    localparam logic [LW-1:0]    C_LAST_POS = LW'(N - 2);

    mc_state_t                 state_q, state_d;
    tile_t [N-1:0][N-1:0]      board_q, board_d;
    logic [3:0]                dir_q, dir_d;
    logic [3:0]                rem_q, rem_d;
    logic [LW-1:0]             pos_q, pos_d, pos_p1;
    logic [3:0]                can_move_q, can_move_d;
    logic                      any_move_q, any_move_d;
    logic                      game_over_q, game_over_d;
    logic                      pair_hit;
    logic                      last_step;

    assign pos_p1 = pos_q + 1'b1;

`ifdef MOVE_CHECK_LINE_PARALLEL_EN
    logic [N-1:0] lane_hit;

    for (genvar l = 0; l < N; l++) begin : g_lane
        tile_t src, dst;

        always_comb begin
            src = '0;
            dst = '0;
            case (dir_q)
                DIR_RIGHT: begin src = board_q[l][pos_q];  dst = board_q[l][pos_p1]; end
                DIR_LEFT:  begin src = board_q[l][pos_p1]; dst = board_q[l][pos_q];  end
                DIR_DOWN:  begin src = board_q[pos_q][l];  dst = board_q[pos_p1][l]; end
                DIR_UP:    begin src = board_q[pos_p1][l]; dst = board_q[pos_q][l];  end
                default:   begin src = '0;                 dst = '0;                 end
            endcase
        end

        tile_pair_mergeable #(.W(W)) u_pair (
            .src (src),
            .dst (dst),
            .hit (lane_hit[l])
        );
    end

    assign pair_hit  = |lane_hit;
    assign last_step = (pos_q == C_LAST_POS);
`else
    localparam logic [LW-1:0] C_LAST_LINE = LW'(N - 1);

    logic [LW-1:0] line_q, line_d;
    tile_t         src, dst;

    always_comb begin
        src = '0;
        dst = '0;
        case (dir_q)
            DIR_RIGHT: begin src = board_q[line_q][pos_q];  dst = board_q[line_q][pos_p1]; end
            DIR_LEFT:  begin src = board_q[line_q][pos_p1]; dst = board_q[line_q][pos_q];  end
            DIR_DOWN:  begin src = board_q[pos_q][line_q];  dst = board_q[pos_p1][line_q]; end
            DIR_UP:    begin src = board_q[pos_p1][line_q]; dst = board_q[pos_q][line_q];  end
            default:   begin src = '0;                      dst = '0;                      end
        endcase
    end

    tile_pair_mergeable #(.W(W)) u_pair (
        .src (src),
        .dst (dst),
        .hit (pair_hit)
    );

    assign last_step = (line_q == C_LAST_LINE) && (pos_q == C_LAST_POS);
`endif

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        dir_d       = dir_q;
        rem_d       = rem_q;
        pos_d       = pos_q;
        can_move_d  = can_move_q;
        any_move_d  = any_move_q;
        game_over_d = game_over_q;
`ifndef MOVE_CHECK_LINE_PARALLEL_EN
        line_d      = line_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    board_d     = matrix;
                    can_move_d  = 4'b0000;
                    any_move_d  = 1'b0;
                    game_over_d = 1'b0;
                    pos_d       = '0;
`ifndef MOVE_CHECK_LINE_PARALLEL_EN
                    line_d      = '0;
`endif
                    dir_d       = msb_onehot(dir_mask);
                    rem_d       = dir_mask & ~msb_onehot(dir_mask);
                    state_d     = (dir_mask != 4'b0000) ? SCAN : FIN;
                end
            end
            SCAN: begin
                if (pair_hit || last_step) begin
                    // A hit ends this direction early; the bit was cleared at accept.
                    can_move_d = can_move_q | (pair_hit ? dir_q : 4'b0000);
                    pos_d      = '0;
`ifndef MOVE_CHECK_LINE_PARALLEL_EN
                    line_d     = '0;
`endif
                    if (rem_q != 4'b0000) begin
                        dir_d = msb_onehot(rem_q);
                        rem_d = rem_q & ~msb_onehot(rem_q);
                    end else begin
                        state_d     = FIN;
                        any_move_d  = |can_move_d;
                        game_over_d = (can_move_d == 4'b0000);
                    end
                end else begin
`ifdef MOVE_CHECK_LINE_PARALLEL_EN
                    pos_d = pos_p1;
`else
                    if (pos_q == C_LAST_POS) begin
                        pos_d  = '0;
                        line_d = line_q + 1'b1;
                    end else begin
                        pos_d  = pos_p1;
                    end
`endif
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            board_q     <= '0;
            dir_q       <= 4'b0000;
            rem_q       <= 4'b0000;
            pos_q       <= '0;
            can_move_q  <= 4'b0000;
            any_move_q  <= 1'b0;
            game_over_q <= 1'b0;
`ifndef MOVE_CHECK_LINE_PARALLEL_EN
            line_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            dir_q       <= dir_d;
            rem_q       <= rem_d;
            pos_q       <= pos_d;
            can_move_q  <= can_move_d;
            any_move_q  <= any_move_d;
            game_over_q <= game_over_d;
`ifndef MOVE_CHECK_LINE_PARALLEL_EN
            line_q      <= line_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign can_move  = can_move_q;
    assign any_move  = any_move_q;
    assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_move_checker_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_checker_seq
// Description : Directed self-checking bench for move_checker_seq (N=4, W=12).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_checker_seq;

    localparam int N = 4;
    localparam int W = 12;

`ifdef MOVE_CHECK_LINE_PARALLEL_EN
    localparam int LAT_FULL = 13;
    localparam int LAT_TWO  = 7;
    localparam int LAT_MID  = 9;
`else
    localparam int LAT_FULL = 49;
    localparam int LAT_TWO  = 25;
    localparam int LAT_MID  = 27;
`endif

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic [3:0]                 dir_mask;
    logic [N-1:0][N-1:0][W-1:0] matrix;
    logic                       busy;
    logic                       done;
    logic [3:0]                 can_move;
    logic                       any_move;
    logic                       game_over;

    int n_checks;
    int n_errors;

    move_checker_seq #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir_mask  (dir_mask),
        .matrix    (matrix),
        .busy      (busy),
        .done      (done),
        .can_move  (can_move),
        .any_move  (any_move),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues a request accepted at edge 0; returns the cycle done is seen (-1 on timeout).
    task automatic run_req(input logic [3:0] mask, output int lat);
        @(negedge clk);
        dir_mask = mask;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [3:0] exp_cm, input logic exp_go);
        check_eq({tag, "_lat"},  lat,       exp_lat);
        check_eq({tag, "_cm"},   can_move,  exp_cm);
        check_eq({tag, "_any"},  any_move,  |exp_cm);
        check_eq({tag, "_go"},   game_over, exp_go);
    endtask

    int lat;
    int done_cnt;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dir_mask = 4'b0000;
        matrix   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_cm",   can_move, 4'b0000);
        check_eq("rst_any",  any_move, 1'b0);
        check_eq("rst_go",   game_over, 1'b0);
        rst = 1'b0;

        // Empty board: nothing can move in any direction, full-length scan.
        matrix = '0;
        run_req(4'b1111, lat);
        check_result("empty", lat, LAT_FULL, 4'b0000, 1'b1);
        check_eq("empty_busy", busy, 1'b1);

        // Results hold after the done pulse.
        repeat (3) @(negedge clk);
        check_eq("hold_done", done, 1'b0);
        check_eq("hold_busy", busy, 1'b0);
        check_eq("hold_go",   game_over, 1'b1);

        // Single tile in the top-left corner can slide right and down.
        matrix       = '0;
        matrix[0][0] = 12'd2;
        run_req(4'b1111, lat);
        check_eq("single_done", lat > 0, 1'b1);
        check_eq("single_cm",   can_move, 4'b0101);
        check_eq("single_any",  any_move, 1'b1);
        check_eq("single_go",   game_over, 1'b0);

        // Full checkerboard of 2/4: locked.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                matrix[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        run_req(4'b1111, lat);
        check_result("checker", lat, LAT_FULL, 4'b0000, 1'b1);

        // Horizontal-only merge on row 0.
        matrix[0][0] = 12'd2; matrix[0][1] = 12'd2; matrix[0][2] = 12'd4; matrix[0][3] = 12'd8;
        matrix[1][0] = 12'd4; matrix[1][1] = 12'd8; matrix[1][2] = 12'd2; matrix[1][3] = 12'd4;
        matrix[2][0] = 12'd2; matrix[2][1] = 12'd4; matrix[2][2] = 12'd8; matrix[2][3] = 12'd2;
        matrix[3][0] = 12'd4; matrix[3][1] = 12'd8; matrix[3][2] = 12'd2; matrix[3][3] = 12'd4;
        run_req(4'b1001, lat);
        check_eq("row_lr_done", lat > 0, 1'b1);
        check_eq("row_lr_cm",   can_move, 4'b1001);
        check_eq("row_lr_any",  any_move, 1'b1);
        check_eq("row_lr_go",   game_over, 1'b0);
        run_req(4'b0110, lat);
        check_result("row_ud", lat, LAT_TWO, 4'b0000, 1'b1);

        // Empty mask completes immediately with no game-over.
        run_req(4'b0000, lat);
        check_result("mask0", lat, 1, 4'b0000, 1'b0);

        // Mid-scan start and board overwrite must not disturb the running check.
        matrix       = '0;
        matrix[0][0] = 12'd2;
        @(negedge clk);
        dir_mask = 4'b1111;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 3) begin
                matrix   = '0;
                dir_mask = 4'b0000;
                start    = 1'b1;
            end
            if (c == 4) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        check_result("midscan", lat, LAT_MID, 4'b0101, 1'b0);

        // Reset in the middle of a scan aborts it without a done pulse.
        matrix = '0;
        @(negedge clk);
        dir_mask = 4'b1111;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_cm",   can_move, 4'b0000);
        check_eq("abort_any",  any_move, 1'b0);
        check_eq("abort_go",   game_over, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("abort_nodone", done_cnt, 0);

        matrix       = '0;
        matrix[0][0] = 12'd2;
        run_req(4'b1111, lat);
        check_result("after_abort", lat, LAT_MID, 4'b0101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
